exec_muldiv_unit: RTL and testbench

EXEC_MULDIV_UNIT -- requirements
Module: exec_muldiv_unit

---
 rtl/exec_muldiv_unit_if.sv | 39 +++
 rtl/exec_muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_exec_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_muldiv_unit_if.sv
// EX-stage multiply/divide unit request/response bundle.
// The master drives the decoded instruction; the slave stalls and reports.
interface exec_muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              i_valid;
    logic [3:0]        is_ALUop;
    logic [5:0]        i_func;
    logic [DATA_W-1:0] i_a;
    logic [DATA_W-1:0] i_b;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_result;
    logic              o_div_by_zero;

    modport master (
        output i_valid,
        output is_ALUop,
        output i_func,
        output i_a,
        output i_b,
        input  o_busy,
        input  o_done,
        input  o_result,
        input  o_div_by_zero
    );

    modport slave (
        input  i_valid,
        input  is_ALUop,
        input  i_func,
        input  i_a,
        input  i_b,
        output o_busy,
        output o_done,
        output o_result,
        output o_div_by_zero
    );
endinterface

// File: rtl/exec_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply, restoring divide, one sign-fix cycle.
module exec_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input logic              i_clk,
    input logic              i_rst_n,
    exec_muldiv_unit_if.slave bus
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] wh_q;
    logic [DATA_W-1:0] wl_q;
    logic [DATA_W-1:0] opd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              is_div_q;
    logic              neg_lo_q;
    logic              neg_hi_q;
    logic              dz_q;
    logic              dzp_q;

    logic              rtype;
    logic              is_mul;
    logic              is_div;
    logic              div_go;
    logic              dz_hit;
    logic              do_mthi;
    logic              do_mtlo;
    logic              sgn;
    logic              sa;
    logic              sb;
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;

    logic [DATA_W:0]     msum;
    logic [DATA_W:0]     rsh;
    logic [DATA_W:0]     dif;
    logic [2*DATA_W-1:0] pneg;

    // Instruction decode; only an R-type in IDLE can start anything.
    always_comb begin
        rtype   = bus.i_valid && (bus.is_ALUop == 4'b0000)
                  && (state_q == S_IDLE);
        is_mul  = 1'b0;
        is_div  = 1'b0;
        do_mthi = 1'b0;
        do_mtlo = 1'b0;
        unique case (1'b1)
            (bus.i_func == F_MULT),
            (bus.i_func == F_MULTU): is_mul  = rtype;
            (bus.i_func == F_DIV),
            (bus.i_func == F_DIVU):  is_div  = rtype;
            (bus.i_func == F_MTHI):  do_mthi = rtype;
            (bus.i_func == F_MTLO):  do_mtlo = rtype;
            default: ;
        endcase
        dz_hit = is_div && (bus.i_b == '0);
        div_go = is_div && (bus.i_b != '0);
        // MULT and DIV have funct bit 0 clear; the U forms have it set.
        sgn    = ~bus.i_func[0];
        sa     = sgn && bus.i_a[DATA_W-1];
        sb     = sgn && bus.i_b[DATA_W-1];
        abs_a  = sa ? (~bus.i_a + 1'b1) : bus.i_a;
        abs_b  = sb ? (~bus.i_b + 1'b1) : bus.i_b;
    end

    // One iteration step of each algorithm plus the product negation.
    always_comb begin
        msum = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opd_q} : '0);
        rsh  = {wh_q, wl_q[DATA_W-1]};
        dif  = rsh - {1'b0, opd_q};
        pneg = ~{wh_q, wl_q} + 1'b1;
    end

    // Control state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (is_mul) begin
                    state_d = S_MUL;
                end else if (div_go) begin
                    state_d = S_DIV;
                end
            end
            S_MUL:   if (cnt_q == LAST) state_d = S_FIX;
            S_DIV:   if (cnt_q == LAST) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, sign fix and HI/LO commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            wh_q     <= '0;
            wl_q     <= '0;
            opd_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_mul || div_go) begin
                        wh_q     <= '0;
                        wl_q     <= is_mul ? abs_b : abs_a;
                        opd_q    <= is_mul ? abs_a : abs_b;
                        cnt_q    <= '0;
                        is_div_q <= div_go;
                        neg_lo_q <= sa ^ sb;
                        neg_hi_q <= is_mul ? (sa ^ sb) : sa;
                    end
                    if (do_mthi) hi_q <= bus.i_a;
                    if (do_mtlo) lo_q <= bus.i_a;
                end
                S_MUL: begin
                    {wh_q, wl_q} <= {msum, wl_q[DATA_W-1:1]};
                    cnt_q        <= cnt_q + 1'b1;
                end
                S_DIV: begin
                    wh_q  <= dif[DATA_W] ? rsh[DATA_W-1:0]
                                         : dif[DATA_W-1:0];
                    wl_q  <= {wl_q[DATA_W-2:0], ~dif[DATA_W]};
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIX: begin
                    if (is_div_q) begin
                        if (neg_lo_q) wl_q <= ~wl_q + 1'b1;
                        if (neg_hi_q) wh_q <= ~wh_q + 1'b1;
                    end else if (neg_lo_q) begin
                        {wh_q, wl_q} <= pneg;
                    end
                end
                S_DONE: begin
                    hi_q <= wh_q;
                    lo_q <= wl_q;
                end
                default: ;
            endcase
        end
    end

    // Sticky divide-by-zero flag and its one-cycle completion pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dz_q  <= 1'b0;
            dzp_q <= 1'b0;
        end else begin
            if (dz_hit) dz_q <= 1'b1;
            dzp_q <= dz_hit;
        end
    end

    assign bus.o_busy        = (state_q != S_IDLE);
    assign bus.o_done        = (state_q == S_DONE) || dzp_q;
    assign bus.o_div_by_zero = dz_q;
    assign bus.o_result      = (bus.i_func == F_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed bench for exec_muldiv_unit.
// Hand-computed HI/LO, latency and busy-cycle expectations.
module tb_exec_muldiv_unit;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_NOP   = 6'b111111;

    logic clk;
    logic rst_n;
    int   cmps;
    int   errs;
    int   lat;
    int   bsy;
    int   dn;
    logic [31:0] hi;
    logic [31:0] lo;

    exec_muldiv_unit_if #(.DATA_W(32)) bus ();

    exec_muldiv_unit #(
        .DATA_W(32),
        .CNT_W (6)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.is_ALUop = op;
        bus.i_func   = f;
        bus.i_a      = a;
        bus.i_b      = b;
        @(negedge clk);
        bus.i_valid  = 1'b0;
        bus.is_ALUop = 4'b0000;
        bus.i_func   = F_NOP;
    endtask

    task automatic wait_done(output int l, output int b);
        l = 0;
        b = 0;
        for (int n = 1; n <= 100; n++) begin
            if (bus.o_busy) b++;
            if (bus.o_done) begin
                l = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        @(negedge clk);
        bus.i_func = F_MFHI;
        #1 h = bus.o_result;
        bus.i_func = F_MFLO;
        #1 l = bus.o_result;
        bus.i_func = F_NOP;
    endtask

    initial begin
        cmps = 0;
        errs = 0;
        rst_n = 1'b0;
        bus.i_valid  = 1'b0;
        bus.is_ALUop = 4'b0000;
        bus.i_func   = F_MFHI;
        bus.i_a      = '0;
        bus.i_b      = '0;

        #12;
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_dz", bus.o_div_by_zero, 0);
        chk("rst_hi", bus.o_result, 0);
        bus.i_func = F_MFLO;
        #1 chk("rst_lo", bus.o_result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // MULT -2 * 3
        issue(4'b0000, F_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done(lat, bsy);
        chk("mult_lat", lat, 34);
        chk("mult_busy", bsy, 34);
        read_hilo(hi, lo);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // MULT -5 * -6
        issue(4'b0000, F_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
        wait_done(lat, bsy);
        read_hilo(hi, lo);
        chk("multnn_hi", hi, 32'h0000_0000);
        chk("multnn_lo", lo, 32'h0000_001E);

        // MULTU max * max
        issue(4'b0000, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bsy);
        read_hilo(hi, lo);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        // DIV -7 / 2
        issue(4'b0000, F_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(lat, bsy);
        chk("div_lat", lat, 34);
        read_hilo(hi, lo);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);

        // DIV 7 / -2
        issue(4'b0000, F_DIV, 32'h0000_0007, 32'hFFFF_FFFE);
        wait_done(lat, bsy);
        read_hilo(hi, lo);
        chk("divpn_hi", hi, 32'h0000_0001);
        chk("divpn_lo", lo, 32'hFFFF_FFFD);

        // DIV overflow
        issue(4'b0000, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bsy);
        read_hilo(hi, lo);
        chk("divov_hi", hi, 32'h0000_0000);
        chk("divov_lo", lo, 32'h8000_0000);
        chk("divov_dz", bus.o_div_by_zero, 0);

        // DIVU 100 / 7
        issue(4'b0000, F_DIVU, 32'd100, 32'd7);
        wait_done(lat, bsy);
        chk("divu_busy", bsy, 34);
        read_hilo(hi, lo);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);

        // DIVU by zero
        issue(4'b0000, F_DIVU, 32'd5, 32'd0);
        wait_done(lat, bsy);
        chk("dz_lat", lat, 1);
        chk("dz_busy", bsy, 0);
        chk("dz_flag", bus.o_div_by_zero, 1);
        read_hilo(hi, lo);
        chk("dz_hi", hi, 32'd2);
        chk("dz_lo", lo, 32'd14);

        // MTHI / MTLO then reads
        issue(4'b0000, F_MTHI, 32'h0000_1234, 32'd0);
        chk("mthi_busy", bus.o_busy, 0);
        chk("mthi_done", bus.o_done, 0);
        issue(4'b0000, F_MTLO, 32'h0000_5678, 32'd0);
        chk("mtlo_busy", bus.o_busy, 0);
        read_hilo(hi, lo);
        chk("mf_hi", hi, 32'h0000_1234);
        chk("mf_lo", lo, 32'h0000_5678);
        chk("dz_sticky", bus.o_div_by_zero, 1);

        // Non R-type class is a no-op
        issue(4'b0001, F_MULT, 32'd9, 32'd9);
        chk("nonr_busy", bus.o_busy, 0);
        read_hilo(hi, lo);
        chk("nonr_hi", hi, 32'h0000_1234);

        // MTHI then MULT back-to-back, MTLO during MUL ignored
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_func  = F_MTHI;
        bus.i_a     = 32'h0000_DEAD;
        @(negedge clk);
        bus.i_func  = F_MULT;
        bus.i_a     = 32'd2;
        bus.i_b     = 32'd3;
        @(negedge clk);
        bus.i_func  = F_MTLO;
        bus.i_a     = 32'h0000_AAAA;
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_func  = F_NOP;
        wait_done(lat, bsy);
        chk("b2b_lat", lat, 33);
        read_hilo(hi, lo);
        chk("b2b_hi", hi, 32'd0);
        chk("b2b_lo", lo, 32'd6);

        // Reset in the middle of DIVU
        issue(4'b0000, F_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", bus.o_busy, 0);
        chk("mrst_done", bus.o_done, 0);
        chk("mrst_dz", bus.o_div_by_zero, 0);
        chk("mrst_res", bus.o_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_done) dn++;
        end
        chk("mrst_nodone", dn, 0);
        read_hilo(hi, lo);
        chk("mrst_hi", hi, 32'd0);
        chk("mrst_lo", lo, 32'd0);

        issue(4'b0000, F_MULTU, 32'd3, 32'd4);
        wait_done(lat, bsy);
        chk("post_lat", lat, 34);
        read_hilo(hi, lo);
        chk("post_hi", hi, 32'd0);
        chk("post_lo", lo, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
